// File: rtl/pc_gen_unit_pkg.sv
// Shared types and helpers for the fetch-stage PC generator.
//   pcsrc_e    : next-PC source select driven by the decode/execute stage
//   state_e    : fetch FSM states
//   align_mask : low-bit mask that a legal fetch target must leave clear
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PcSeq  = 2'b00,
    PcBr   = 2'b01,
    PcJalr = 2'b10,
    PcRsvd = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StTrap = 2'b10
  } state_e;

  function automatic logic [31:0] align_mask(input int unsigned align_bits);
    return (32'd1 << align_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Bundle of all non-clock/reset signals of the PC generator.
//   master : pipeline side (drives control/operands, observes PC and status)
//   slave  : PC generator side
// Signals: stall, PCSrc, ImmExt, RegBase, redirect_valid, redirect_pc, trap_ack (to PC gen);
//          PCounter, PCPlus4, fetch_valid, misalign_trap, trap_pc, fetch_count (from PC gen).
interface pc_gen_unit_if
  import pc_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  stall;
  pcsrc_e                PCSrc;
  logic [DATA_WIDTH-1:0] ImmExt;
  logic [DATA_WIDTH-1:0] RegBase;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  trap_ack;
  logic [DATA_WIDTH-1:0] PCounter;
  logic [DATA_WIDTH-1:0] PCPlus4;
  logic                  fetch_valid;
  logic                  misalign_trap;
  logic [DATA_WIDTH-1:0] trap_pc;
  logic [CNT_WIDTH-1:0]  fetch_count;

  modport master (
    output stall, PCSrc, ImmExt, RegBase, redirect_valid, redirect_pc, trap_ack,
    input  PCounter, PCPlus4, fetch_valid, misalign_trap, trap_pc, fetch_count
  );

  modport slave (
    input  stall, PCSrc, ImmExt, RegBase, redirect_valid, redirect_pc, trap_ack,
    output PCounter, PCPlus4, fetch_valid, misalign_trap, trap_pc, fetch_count
  );
endinterface

// File: rtl/pc_gen_unit_target_calc.sv
// Combinational next-PC target selection.
//   pc_i, imm_i, reg_base_i : current PC, immediate, rs1 value
//   pc_src_i                : sequential / branch / JALR select (reserved acts as sequential)
//   redirect_valid_i/pc_i   : late-stage redirect, takes precedence over pc_src_i
//   seq_o                   : PC + instruction size
//   target_o, misalign_o    : selected target and whether its low bits are non-zero
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] reg_base_i,
  input  pcsrc_e                pc_src_i,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] seq_o,
  output logic [DATA_WIDTH-1:0] target_o,
  output logic                  misalign_o
);
  localparam logic [DATA_WIDTH-1:0] Step = DATA_WIDTH'(32'd1 << ALIGN_BITS);
  localparam logic [DATA_WIDTH-1:0] Mask = DATA_WIDTH'(align_mask(ALIGN_BITS));

  logic [DATA_WIDTH-1:0] br;
  logic [DATA_WIDTH-1:0] jalr;

  // All sums wrap at DATA_WIDTH; carries are intentionally dropped.
  assign seq_o = pc_i + Step;
  assign br    = pc_i + imm_i;
  assign jalr  = (reg_base_i + imm_i) & ~DATA_WIDTH'(1);

  always_comb begin
    target_o = seq_o;
    if (redirect_valid_i) begin
      target_o = redirect_pc_i;
    end else begin
      unique case (pc_src_i)
        PcBr:    target_o = br;
        PcJalr:  target_o = jalr;
        default: target_o = seq_o;
      endcase
    end
  end

  assign misalign_o = |(target_o & Mask);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_gen_unit_if slave port (control/operands in, PC/status out)
// Holds the BOOT/RUN/TRAP FSM, the PC register, the captured trap target and a wrapping
// count of accepted fetches.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned ALIGN_BITS   = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input logic            clk,
  input logic            rst,
  pc_gen_unit_if.slave   bus
);
  localparam logic [DATA_WIDTH-1:0] ResetPc = DATA_WIDTH'(RESET_VECTOR);
  localparam logic [DATA_WIDTH-1:0] TrapPc  = DATA_WIDTH'(TRAP_VECTOR);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] seq;
  logic [DATA_WIDTH-1:0] target;
  logic                  misalign;

  pc_target_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target_calc (
    .pc_i             (pc_q),
    .imm_i            (bus.ImmExt),
    .reg_base_i       (bus.RegBase),
    .pc_src_i         (bus.PCSrc),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_pc_i    (bus.redirect_pc),
    .seq_o            (seq),
    .target_o         (target),
    .misalign_o       (misalign)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        // Redirect beats stall; a plain stall holds and skips the misalign check.
        if (bus.redirect_valid || !bus.stall) begin
          if (misalign) begin
            pc_d      = TrapPc;
            trap_pc_d = target;
            state_d   = StTrap;
          end else begin
            pc_d = target;
            if (!bus.redirect_valid) cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      StTrap: begin
        if (bus.trap_ack) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StBoot;
      pc_q      <= ResetPc;
      trap_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PCounter      = pc_q;
  assign bus.PCPlus4       = seq;
  assign bus.fetch_valid   = (state_q == StRun);
  assign bus.misalign_trap = (state_q == StTrap);
  assign bus.trap_pc       = trap_pc_q;
  assign bus.fetch_count   = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;
  import pc_gen_pkg::*;

  logic clk;
  logic rst;
  logic rst8;
  int   total;
  int   passed;

  pc_gen_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) if32 ();
  pc_gen_unit_if #(.DATA_WIDTH(8),  .CNT_WIDTH(4))  if8 ();

  pc_gen_unit #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .ALIGN_BITS   (2),
    .CNT_WIDTH    (32)
  ) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  pc_gen_unit #(
    .DATA_WIDTH   (8),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .ALIGN_BITS   (2),
    .CNT_WIDTH    (4)
  ) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    rst8   = 1'b1;
    if32.stall = 1'b0; if32.PCSrc = PcSeq; if32.ImmExt = '0; if32.RegBase = '0;
    if32.redirect_valid = 1'b0; if32.redirect_pc = '0; if32.trap_ack = 1'b0;
    if8.stall = 1'b0; if8.PCSrc = PcSeq; if8.ImmExt = '0; if8.RegBase = '0;
    if8.redirect_valid = 1'b0; if8.redirect_pc = '0; if8.trap_ack = 1'b0;

    // Reset and boot
    step();
    step();
    check("rst_pc", 64'(if32.PCounter), 64'h0);
    check("rst_fv", 64'(if32.fetch_valid), 64'h0);
    check("rst_trap", 64'(if32.misalign_trap), 64'h0);
    check("rst_cnt", 64'(if32.fetch_count), 64'h0);
    check("rst_trap_pc", 64'(if32.trap_pc), 64'h0);
    rst = 1'b0;
    step();
    check("boot_pc", 64'(if32.PCounter), 64'h0);
    check("boot_fv", 64'(if32.fetch_valid), 64'h1);
    check("boot_pcplus4", 64'(if32.PCPlus4), 64'h4);
    step();
    check("seq_pc4", 64'(if32.PCounter), 64'h4);
    step();
    check("seq_pc8", 64'(if32.PCounter), 64'h8);
    check("seq_cnt2", 64'(if32.fetch_count), 64'h2);
    step();
    step();
    check("seq_pc10", 64'(if32.PCounter), 64'h10);

    // Branch and JALR
    if32.PCSrc = PcBr; if32.ImmExt = 32'hFFFF_FFF8;
    step();
    check("br_pc", 64'(if32.PCounter), 64'h8);
    check("br_cnt", 64'(if32.fetch_count), 64'h5);
    if32.PCSrc = PcJalr; if32.RegBase = 32'h41; if32.ImmExt = 32'h3;
    step();
    check("jalr_pc", 64'(if32.PCounter), 64'h44);
    check("jalr_pcplus4", 64'(if32.PCPlus4), 64'h48);
    check("jalr_cnt", 64'(if32.fetch_count), 64'h6);

    // Stall, then stall with redirect
    if32.PCSrc = PcSeq; if32.stall = 1'b1;
    step();
    step();
    step();
    check("stall_pc", 64'(if32.PCounter), 64'h44);
    check("stall_cnt", 64'(if32.fetch_count), 64'h6);
    check("stall_fv", 64'(if32.fetch_valid), 64'h1);
    if32.redirect_valid = 1'b1; if32.redirect_pc = 32'h200;
    step();
    check("redir_pc", 64'(if32.PCounter), 64'h200);
    check("redir_cnt", 64'(if32.fetch_count), 64'h6);

    // Misaligned branch target
    if32.stall = 1'b0; if32.redirect_pc = 32'h20;
    step();
    check("redir2_pc", 64'(if32.PCounter), 64'h20);
    if32.redirect_valid = 1'b0; if32.PCSrc = PcBr; if32.ImmExt = 32'h6;
    step();
    check("trap_pc_reg", 64'(if32.PCounter), 64'h100);
    check("trap_target", 64'(if32.trap_pc), 64'h26);
    check("trap_flag", 64'(if32.misalign_trap), 64'h1);
    check("trap_fv", 64'(if32.fetch_valid), 64'h0);
    check("trap_cnt", 64'(if32.fetch_count), 64'h6);
    // Redirect/stall must be ignored while trapped
    if32.redirect_valid = 1'b1; if32.redirect_pc = 32'h300; if32.stall = 1'b1;
    step();
    check("trap_hold_pc", 64'(if32.PCounter), 64'h100);
    check("trap_hold_flag", 64'(if32.misalign_trap), 64'h1);
    if32.redirect_valid = 1'b0; if32.stall = 1'b0; if32.PCSrc = PcSeq; if32.trap_ack = 1'b1;
    step();
    check("ack_pc", 64'(if32.PCounter), 64'h100);
    check("ack_fv", 64'(if32.fetch_valid), 64'h1);
    check("ack_flag", 64'(if32.misalign_trap), 64'h0);
    if32.trap_ack = 1'b0;
    step();
    check("resume_pc", 64'(if32.PCounter), 64'h104);
    check("resume_cnt", 64'(if32.fetch_count), 64'h7);

    // Misaligned redirect target
    if32.redirect_valid = 1'b1; if32.redirect_pc = 32'h202;
    step();
    check("rtrap_pc", 64'(if32.PCounter), 64'h100);
    check("rtrap_target", 64'(if32.trap_pc), 64'h202);
    if32.redirect_valid = 1'b0;

    // Reset mid-trap
    rst = 1'b1;
    step();
    check("rtrp_pc", 64'(if32.PCounter), 64'h0);
    check("rtrp_trap_pc", 64'(if32.trap_pc), 64'h0);
    check("rtrp_cnt", 64'(if32.fetch_count), 64'h0);
    check("rtrp_flag", 64'(if32.misalign_trap), 64'h0);
    check("rtrp_fv", 64'(if32.fetch_valid), 64'h0);
    rst = 1'b0;
    step();
    step();
    step();
    check("reboot_pc", 64'(if32.PCounter), 64'h8);

    // Reset mid-stall
    if32.stall = 1'b1;
    step();
    check("pre_rst_stall_pc", 64'(if32.PCounter), 64'h8);
    rst = 1'b1;
    step();
    check("rstall_pc", 64'(if32.PCounter), 64'h0);
    check("rstall_cnt", 64'(if32.fetch_count), 64'h0);
    check("rstall_fv", 64'(if32.fetch_valid), 64'h0);
    rst = 1'b0; if32.stall = 1'b0;

    // 8-bit PC wrap and 4-bit counter wrap
    rst8 = 1'b0;
    step();
    if8.redirect_valid = 1'b1; if8.redirect_pc = 8'hFC;
    step();
    check("w8_pc_fc", 64'(if8.PCounter), 64'hFC);
    check("w8_pcplus4", 64'(if8.PCPlus4), 64'h00);
    if8.redirect_valid = 1'b0;
    step();
    check("w8_pc_wrap", 64'(if8.PCounter), 64'h00);
    check("w8_cnt1", 64'(if8.fetch_count), 64'h1);
    for (int i = 0; i < 14; i++) step();
    check("w8_cnt15", 64'(if8.fetch_count), 64'hF);
    step();
    check("w8_cnt_wrap", 64'(if8.fetch_count), 64'h0);
    check("w8_pc_3c", 64'(if8.PCounter), 64'h3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
